// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM encodings, register-file constants
// and the register-hazard compare helper.
package pc_sequencer_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    HALTED    = 2'd2,
    UNUSED    = 2'd3
  } seq_state_e;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // A producer register matches a consumer only if it is a real (non-zero) register.
  function automatic logic reg_match(input logic [REG_W-1:0] producer,
                                     input logic [REG_W-1:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX writes a register read by the instruction in ID.
module hazard_detect
  import pc_sequencer_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use_c
);

  always_comb begin
    load_use_c = idex_memread &&
                 (reg_match(idex_rt, ifid_rs) || reg_match(idex_rt, ifid_rt));
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: selects the PC source, generates pipeline stall/flush controls,
// holds redirects that arrive while fetch is stalled, and counts stall cycles.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc_plus4,
  input  logic [N-1:0]     branch_target,
  input  logic [N-1:0]     jump_target,
  input  logic [N-1:0]     jr_target,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             imem_ready,
  input  logic             halt,
  output logic [N-1:0]     new_pc,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [STATE_W-1:0] seq_state,
  output logic [CW-1:0]    stall_count
);

  seq_state_e   state_q, state_d;
  logic         pend_valid_q, pend_valid_d;
  logic [N-1:0] pend_target_q, pend_target_d;
  logic         load_use;
  logic         redirect;
  logic [N-1:0] redirect_target;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use_c   (load_use)
  );

  // Redirect request and its target: branch beats jr beats jump.
  always_comb begin
    redirect = branch_taken | jr | jump;
    if (branch_taken)  redirect_target = branch_target;
    else if (jr)       redirect_target = jr_target;
    else               redirect_target = jump_target;
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    new_pc        = pc_plus4;
    pc_enable     = 1'b0;
    ifid_enable   = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;

    case (state_q)
      RUN: begin
        if (halt) begin
          ifid_flush    = 1'b1;
          state_d       = HALTED;
          pend_valid_d  = 1'b0;
          pend_target_d = '0;
        end else if (!imem_ready) begin
          ifid_flush  = 1'b1;
          ifid_enable = 1'b1;
          state_d     = IMEM_WAIT;
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end else if (load_use) begin
          idex_bubble = 1'b1;
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end else if (pend_valid_q) begin
          // A held redirect wins; a fresh one this cycle becomes the new held one.
          new_pc        = pend_target_q;
          pc_enable     = 1'b1;
          ifid_enable   = 1'b1;
          ifid_flush    = 1'b1;
          pend_valid_d  = redirect;
          pend_target_d = redirect ? redirect_target : '0;
        end else if (redirect) begin
          new_pc      = redirect_target;
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
        end else begin
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
        end
      end
      IMEM_WAIT: begin
        ifid_flush = 1'b1;
        if (halt) begin
          state_d       = HALTED;
          pend_valid_d  = 1'b0;
          pend_target_d = '0;
        end else begin
          ifid_enable = 1'b1;
          if (imem_ready) state_d = RUN;
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end
      end
      HALTED: begin
        ifid_flush    = 1'b1;
        pend_valid_d  = 1'b0;
        pend_target_d = '0;
      end
      default: begin
        ifid_flush    = 1'b1;
        state_d       = RUN;
        pend_valid_d  = 1'b0;
        pend_target_d = '0;
      end
    endcase

    // Reset holds the pipeline frozen and flushed independently of the clock.
    if (!reset) begin
      new_pc      = pc_plus4;
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Saturating count of fetch-stall cycles; a halted machine is not stalling.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pc_enable && (state_q != HALTED) && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + CW'(1);
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, checked against a
// behavioural model; a second instance with a 4-bit counter covers saturation.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_plus4, branch_target, jump_target, jr_target;
  logic        branch_taken, jump, jr, idex_memread, imem_ready, halt;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;

  logic [31:0] new_pc, s_new_pc;
  logic        pc_enable, ifid_enable, ifid_flush, idex_bubble;
  logic        s_pc_enable, s_ifid_enable, s_ifid_flush, s_idex_bubble;
  logic [1:0]  seq_state, s_seq_state;
  logic [15:0] stall_count;
  logic [3:0]  s_stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: 0 running, 1 waiting on imem, 2 halted.
  int          m_state;
  bit          m_pv;
  logic [31:0] m_pt;
  int          m_stall;
  int          n_state;
  bit          n_pv;
  logic [31:0] n_pt;
  logic [31:0] e_pc;
  bit          e_pce, e_ife, e_fl, e_bub;

  pc_sequencer #(.N(32), .CW(16)) u_dut (
    .clk(clk), .reset(reset), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .branch_taken(branch_taken),
    .jump(jump), .jr(jr), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .imem_ready(imem_ready), .halt(halt),
    .new_pc(new_pc), .pc_enable(pc_enable), .ifid_enable(ifid_enable),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .seq_state(seq_state),
    .stall_count(stall_count)
  );

  pc_sequencer #(.N(32), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .branch_taken(branch_taken),
    .jump(jump), .jr(jr), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .imem_ready(imem_ready), .halt(halt),
    .new_pc(s_new_pc), .pc_enable(s_pc_enable), .ifid_enable(s_ifid_enable),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .seq_state(s_seq_state),
    .stall_count(s_stall_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs and next model state from the current inputs.
  function void model_eval();
    bit          lu, rd;
    logic [31:0] tg;
    lu = idex_memread && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    rd = branch_taken || jr || jump;
    tg = branch_taken ? branch_target : (jr ? jr_target : jump_target);
    e_pc = pc_plus4; e_pce = 0; e_ife = 0; e_fl = 0; e_bub = 0;
    n_state = m_state; n_pv = m_pv; n_pt = m_pt;
    if (!reset) begin
      e_fl = 1; e_bub = 1;
      return;
    end
    if (m_state == 2) begin
      e_fl = 1; n_pv = 0;
    end else if (halt) begin
      e_fl = 1; n_state = 2; n_pv = 0;
    end else if (m_state == 1) begin
      e_fl = 1; e_ife = 1;
      if (imem_ready) n_state = 0;
      if (rd) begin n_pv = 1; n_pt = tg; end
    end else if (!imem_ready) begin
      e_fl = 1; e_ife = 1; n_state = 1;
      if (rd) begin n_pv = 1; n_pt = tg; end
    end else if (lu) begin
      e_bub = 1;
      if (rd) begin n_pv = 1; n_pt = tg; end
    end else begin
      e_pce = 1; e_ife = 1;
      if (m_pv) begin
        e_pc = m_pt; e_fl = 1; n_pv = rd;
        if (rd) n_pt = tg;
      end else if (rd) begin
        e_pc = tg; e_fl = 1;
      end
    end
  endfunction

  task automatic check_all();
    model_eval();
    chk("new_pc", 64'(new_pc), 64'(e_pc));
    chk("pc_enable", 64'(pc_enable), 64'(e_pce));
    chk("ifid_enable", 64'(ifid_enable), 64'(e_ife));
    chk("ifid_flush", 64'(ifid_flush), 64'(e_fl));
    chk("idex_bubble", 64'(idex_bubble), 64'(e_bub));
    chk("seq_state", 64'(seq_state), 64'(m_state));
    chk("stall_count", 64'(stall_count), 64'(m_stall > 65535 ? 65535 : m_stall));
    chk("sat_stall_count", 64'(s_stall_count), 64'(m_stall > 15 ? 15 : m_stall));
    chk("sat_new_pc", 64'(s_new_pc), 64'(e_pc));
  endtask

  task automatic tick();
    model_eval();
    @(negedge clk);
    if (reset) begin
      if (!e_pce && m_state != 2) m_stall++;
      m_state = n_state; m_pv = n_pv; m_pt = n_pt;
    end
    #1;
  endtask

  task automatic cycle();
    #2;
    check_all();
    tick();
  endtask

  task automatic clear_inputs();
    branch_taken = 0; jump = 0; jr = 0; idex_memread = 0; halt = 0; imem_ready = 1;
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // Reset pulse asserted mid-cycle; called at negedge+1.
  task automatic pulse_reset();
    #2;
    reset = 0;
    #1;
    m_state = 0; m_pv = 0; m_pt = '0; m_stall = 0;
    chk("rst_seq_state", 64'(seq_state), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    check_all();
    tick();
    reset = 1;
  endtask

  task automatic rand_inputs(input bit allow_halt);
    pc_plus4      = $urandom;
    branch_target = $urandom;
    jump_target   = $urandom;
    jr_target     = $urandom;
    branch_taken  = ($urandom_range(0, 5) == 0);
    jr            = ($urandom_range(0, 5) == 0);
    jump          = ($urandom_range(0, 5) == 0);
    idex_memread  = ($urandom_range(0, 2) == 0);
    idex_rt       = 5'($urandom_range(0, 3));
    ifid_rs       = 5'($urandom_range(0, 3));
    ifid_rt       = 5'($urandom_range(0, 3));
    imem_ready    = ($urandom_range(0, 4) != 0);
    halt          = allow_halt && ($urandom_range(0, 63) == 0);
  endtask

  int halted_for;
  int s_frozen;

  initial begin
    reset = 0;
    pc_plus4 = '0; branch_target = '0; jump_target = '0; jr_target = '0;
    clear_inputs();
    m_state = 0; m_pv = 0; m_pt = '0; m_stall = 0;
    @(negedge clk);
    #1;
    cycle();
    reset = 1;

    // Plain sequential fetch.
    pc_plus4 = 32'h0000_0008;
    #2;
    check_all();
    chk("seq_new_pc", 64'(new_pc), 64'h8);
    chk("seq_pc_enable", 64'(pc_enable), 64'd1);
    chk("seq_flush", 64'(ifid_flush), 64'd0);
    tick();

    // Imem stall with a branch arriving during the wait.
    pc_plus4 = 32'h0000_000c; branch_target = 32'h0040_0020;
    imem_ready = 0;
    cycle();
    branch_taken = 1;
    #2; check_all(); chk("wait_state_1", 64'(seq_state), 64'd1); tick();
    branch_taken = 0; branch_target = 32'h0;
    #2; check_all(); chk("wait_state_2", 64'(seq_state), 64'd1); tick();
    imem_ready = 1;
    #2; check_all(); chk("wait_state_3", 64'(seq_state), 64'd1);
    chk("wait_stall_count", 64'(stall_count), 64'd3); tick();
    #2; check_all(); chk("wait_pending_pc", 64'(new_pc), 64'h0040_0020);
    chk("wait_pending_flush", 64'(ifid_flush), 64'd1); tick();
    cycle();

    // All three redirects at once.
    branch_taken = 1; jr = 1; jump = 1;
    branch_target = 32'h0040_0100; jr_target = 32'h0040_0200; jump_target = 32'h0040_0300;
    #2; check_all(); chk("prio_new_pc", 64'(new_pc), 64'h0040_0100); tick();
    clear_inputs();

    // Load-use with a concurrent jump that must be deferred one cycle.
    idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8; jump = 1; jump_target = 32'h0000_0200;
    #2; check_all();
    chk("lu_pc_enable", 64'(pc_enable), 64'd0);
    chk("lu_bubble", 64'(idex_bubble), 64'd1); tick();
    clear_inputs();
    #2; check_all(); chk("lu_pending_pc", 64'(new_pc), 64'h200); tick();

    // Long imem stall saturates the 4-bit counter.
    imem_ready = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_count_15", 64'(s_stall_count), 64'hf);
    imem_ready = 1;
    cycle();
    cycle();

    // Halt is sticky and freezes the counter; reset leaves it.
    halt = 1;
    cycle();
    halt = 0;
    s_frozen = m_stall;
    for (int i = 0; i < 10; i++) begin
      #2; check_all();
      chk("halt_state", 64'(seq_state), 64'd2);
      chk("halt_pc_enable", 64'(pc_enable), 64'd0);
      chk("halt_frozen", 64'(stall_count), 64'(s_frozen));
      tick();
    end
    pulse_reset();
    cycle();

    // Random traffic with occasional halts recovered by reset.
    halted_for = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_state == 2 && halted_for >= 4) begin
        halted_for = 0;
        clear_inputs();
        pulse_reset();
      end else begin
        rand_inputs(1'b1);
        halted_for = (m_state == 2) ? halted_for + 1 : 0;
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, the PC and target width.
REQ-002 SHALL have parameter CW, default 16, the stall-counter width.
REQ-003 clk  input  1  clock; all state updates on the falling edge, the same edge the PC register uses.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 pc_plus4, branch_target, jump_target, jr_target  input  N each  candidate next-PC values.
REQ-006 branch_taken, jump, jr  input  1 each  redirect requests resolved in ID.
REQ-007 idex_memread  input  1, idex_rt  input  5, ifid_rs  input  5, ifid_rt  input  5  load-use hazard operands.
REQ-008 imem_ready  input  1  instruction memory has valid data this cycle.
REQ-009 halt  input  1  stop fetching.
REQ-010 new_pc  output  N  value presented to the PC register.
REQ-011 pc_enable  output  1  PC register enable.
REQ-012 ifid_enable  output  1  IF/ID register enable.
REQ-013 ifid_flush  output  1  zero the IF/ID register.
REQ-014 idex_bubble  output  1  zero the ID/EX control fields.
REQ-015 seq_state  output  2  current FSM state.
REQ-016 stall_count  output  CW  saturating count of cycles with pc_enable=0.

Function
REQ-017 SHALL implement FSM states RUN=0, IMEM_WAIT=1, HALTED=2; encoding 3 is unused and SHALL return to RUN on the next edge.
REQ-018 SHALL define load_use = idex_memread AND idex_rt!=0 AND (idex_rt==ifid_rs OR idex_rt==ifid_rt).
REQ-019 SHALL define redirect = branch_taken OR jr OR jump, with target priority branch_target > jr_target > jump_target.
REQ-020 In RUN, condition priority SHALL be: halt > imem_ready=0 > load_use > redirect > sequential.
REQ-021 RUN with halt: pc_enable=0, ifid_flush=1; next state HALTED.
REQ-022 RUN with imem_ready=0: pc_enable=0, ifid_flush=1, ifid_enable=1; next state IMEM_WAIT.
REQ-023 RUN with load_use: pc_enable=0, ifid_enable=0, idex_bubble=1 for that cycle only; state stays RUN; no redirect is taken that cycle.
REQ-024 RUN with redirect: new_pc=selected target, pc_enable=1, ifid_flush=1.
REQ-025 RUN sequential: new_pc=pc_plus4, pc_enable=1, ifid_enable=1; all other controls 0.
REQ-026 A redirect in any cycle where it is not taken, including IMEM_WAIT and load_use cycles, SHALL be latched into pending_valid/pending_target; a later redirect overwrites the latched one.
REQ-027 In IMEM_WAIT: pc_enable=0, ifid_flush=1; on imem_ready=1 the next state is RUN.
REQ-028 On leaving IMEM_WAIT with pending_valid=1, the first RUN cycle SHALL drive new_pc=pending_target with pc_enable=1 and ifid_flush=1, then clear pending_valid; this outranks a fresh redirect.
REQ-029 halt in IMEM_WAIT SHALL move to HALTED and discard any pending redirect.
REQ-030 HALTED is sticky: pc_enable=0, ifid_enable=0, ifid_flush=1; only reset leaves it.
REQ-031 new_pc SHALL be pc_plus4 whenever pc_enable=0.
REQ-032 stall_count SHALL increment on each edge where pc_enable=0 and state is not HALTED, and saturate at all-ones.
REQ-033 All outputs except stall_count and seq_state SHALL be combinational from state, pending registers and inputs, so they are settled before the falling edge.

Reset
REQ-034 reset=0 SHALL immediately force state=RUN, pending_valid=0, pending_target=0 and stall_count=0, regardless of clk.
REQ-035 While reset=0: pc_enable=0, ifid_enable=0, ifid_flush=1, idex_bubble=1, new_pc=pc_plus4, seq_state=0.
REQ-036 Reset asserted during IMEM_WAIT or HALTED SHALL discard all pending state; the first edge after release evaluates RUN.

Structure
REQ-037 A shared package SHALL hold the state encodings (RUN, IMEM_WAIT, HALTED) and the constant REG_ZERO=5'd0.
REQ-038 SHALL contain one sub-module, hazard_detect, which computes load_use combinationally.

Verification
REQ-039 Sequential fetch: pc_plus4=0x00000008, no hazards, imem_ready=1 -> new_pc=0x00000008, pc_enable=1, ifid_flush=0.
REQ-040 Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, with jump=1 -> one cycle of pc_enable=0, idex_bubble=1; pending jump_target taken on the next cycle.
REQ-041 Imem wait: imem_ready=0 for 3 cycles, branch_taken=1 with branch_target=0x00400020 during the wait -> seq_state=1 for 3 cycles; first RUN cycle new_pc=0x00400020; stall_count=3.
REQ-042 Priority: branch_taken, jr and jump all =1 -> new_pc=branch_target.
REQ-043 Halt then reset: halt=1 -> seq_state=2 and pc_enable=0 for 10 cycles with stall_count frozen; reset pulsed low mid-cycle -> seq_state=0 and stall_count=0 immediately.
REQ-044 Saturation: with CW=4, hold imem_ready=0 for 20 cycles -> stall_count=15.
